sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Behavioural model of an asynchronous 16-bit SRAM seen from a synchronous
// controller. The SRAM pins are sampled on every rising edge of clk, decoded
// into WRITE / READ / NONE, and a small FSM produces registered read data with
// a configurable latency and a configurable bus-release (turnaround) time.
// A write that lands while this side is still driving the bus is flagged as
// contention on a sticky error output.
//
// Parameters
//   ADDR_W        address bits used to index the array (depth 2**ADDR_W x 16)
//   READ_LATENCY  edges from a sampled READ to driven data (1..15)
//   TURNAROUND    edges dq_oe stays asserted after a read ends (0..7)
//
// Ports
//   clk           clock, all sampling on the rising edge
//   rst           asynchronous active-low reset
//   address_sram  SRAM address; bits above ADDR_W-1 alias
//   ce_n_sram     chip enable (active low)
//   oe_n_sram     output enable (active low)
//   we_n_sram     write enable (active low)
//   lb_n_sram     lower byte lane enable (active low), dq[7:0]
//   ub_n_sram     upper byte lane enable (active low), dq[15:8]
//   dq_in         write data from the bus
//   dq_out        read data toward the bus
//   dq_oe         per-lane drive enable, bit0 -> dq[7:0], bit1 -> dq[15:8]
//   protocol_err  sticky contention flag (write while driving)
//   wr_count      number of writes that touched at least one lane, wrapping
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int TURNAROUND   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] address_sram,
    input  logic        ce_n_sram,
    input  logic        oe_n_sram,
    input  logic        we_n_sram,
    input  logic        lb_n_sram,
    input  logic        ub_n_sram,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe,
    output logic        protocol_err,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // Counter reload values. The wait counter counts the edges still to come
    // after the one that accepted the READ; the release counter counts the
    // hold edges still to come after the one that ended the read.
    localparam logic [3:0] WAIT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [2:0] REL_LOAD  = 3'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        RD_RELEASE
    } state_t;

    state_t      state_reg,     state_next;
    logic [3:0]  wait_cnt_reg,  wait_cnt_next;
    logic [2:0]  rel_cnt_reg,   rel_cnt_next;
    logic [15:0] dq_out_reg,    dq_out_next;
    logic [1:0]  dq_oe_reg,     dq_oe_next;
    logic        err_reg,       err_next;
    logic [15:0] wr_count_reg,  wr_count_next;

    // -------------------------------------------------------------------------
    // Pin decode
    // -------------------------------------------------------------------------
    logic              cmd_write;
    logic              cmd_read;
    logic [1:0]        lane_en;
    logic [1:0]        lane_wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       rd_data;

    assign cmd_write = ~ce_n_sram & ~we_n_sram;
    assign cmd_read  = ~ce_n_sram &  we_n_sram & ~oe_n_sram;
    assign lane_en   = {~ub_n_sram, ~lb_n_sram};
    assign lane_wr   = cmd_write ? lane_en : 2'b00;
    assign addr      = address_sram[ADDR_W-1:0];

    generate
        if (ADDR_W < 18) begin : g_alias
            // Upper address bits are deliberately ignored so the array aliases.
            logic unused_addr_bits;
            assign unused_addr_bits = ^address_sram[17:ADDR_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Backing store: one byte-wide array per lane so each lane has a single
    // writer. The read path is combinational into dq_out_reg, which makes the
    // read registered and means a write at any earlier edge is always visible.
    // Contents are intentionally not reset.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (lane_wr[gi]) begin
                    mem[addr] <= dq_in[gi*8 +: 8];
                end
            end

            // Disabled lanes read back as zero.
            assign rd_data[gi*8 +: 8] = lane_en[gi] ? mem[addr] : 8'h00;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            rel_cnt_reg  <= 3'd0;
            dq_out_reg   <= 16'h0000;
            dq_oe_reg    <= 2'b00;
            err_reg      <= 1'b0;
            wr_count_reg <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rel_cnt_reg  <= rel_cnt_next;
            dq_out_reg   <= dq_out_next;
            dq_oe_reg    <= dq_oe_next;
            err_reg      <= err_next;
            wr_count_reg <= wr_count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        rel_cnt_next  = rel_cnt_reg;
        dq_out_next   = dq_out_reg;
        dq_oe_next    = dq_oe_reg;
        err_next      = err_reg;
        wr_count_next = wr_count_reg;

        if (cmd_write) begin
            // A write always wins, from any state, and releases the bus.
            state_next    = IDLE;
            wait_cnt_next = 4'd0;
            rel_cnt_next  = 3'd0;
            dq_oe_next    = 2'b00;
            if (|lane_en) begin
                wr_count_next = wr_count_reg + 16'd1;
            end
            if ((state_reg == RD_DRIVE) || (state_reg == RD_RELEASE)) begin
                err_next = 1'b1;
            end
        end else begin
            unique case (state_reg)
                IDLE, RD_RELEASE: begin
                    if (cmd_read) begin
                        // Start (or restart) a read. Data is always taken from
                        // the address sampled at the driving edge, so the
                        // accepted address needs no separate holding register.
                        rel_cnt_next = 3'd0;
                        if (READ_LATENCY == 1) begin
                            state_next  = RD_DRIVE;
                            dq_out_next = rd_data;
                            dq_oe_next  = lane_en;
                        end else begin
                            state_next    = RD_WAIT;
                            wait_cnt_next = WAIT_LOAD;
                            dq_oe_next    = 2'b00;
                        end
                    end else if (state_reg == RD_RELEASE) begin
                        if (rel_cnt_reg == 3'd0) begin
                            state_next = IDLE;
                            dq_oe_next = 2'b00;
                        end else begin
                            rel_cnt_next = rel_cnt_reg - 3'd1;
                        end
                    end
                end

                RD_WAIT: begin
                    if (cmd_read) begin
                        // The edge that would take the counter to zero is the
                        // one that drives data.
                        if (wait_cnt_reg <= 4'd1) begin
                            state_next    = RD_DRIVE;
                            wait_cnt_next = 4'd0;
                            dq_out_next   = rd_data;
                            dq_oe_next    = lane_en;
                        end else begin
                            wait_cnt_next = wait_cnt_reg - 4'd1;
                        end
                    end else begin
                        state_next    = IDLE;
                        wait_cnt_next = 4'd0;
                        dq_oe_next    = 2'b00;
                    end
                end

                RD_DRIVE: begin
                    if (cmd_read) begin
                        dq_out_next = rd_data;
                        dq_oe_next  = lane_en;
                    end else if (TURNAROUND == 0) begin
                        state_next = IDLE;
                        dq_oe_next = 2'b00;
                    end else begin
                        // Hold dq_out/dq_oe while the bus turns around.
                        state_next   = RD_RELEASE;
                        rel_cnt_next = REL_LOAD;
                    end
                end

                default: begin
                    state_next = IDLE;
                    dq_oe_next = 2'b00;
                end
            endcase
        end
    end

    assign dq_out       = dq_out_reg;
    assign dq_oe        = dq_oe_reg;
    assign protocol_err = err_reg;
    assign wr_count     = wr_count_reg;

endmodule
